fht_unload: RTL and testbench
=============================

FHT_UNLOAD -- requirements
Module: fht_unload

Interface
REQ-001 Parameter A_BIT, default 8: bank RAM address width; each bank holds 2^A_BIT points.
REQ-002 Parameter D_BIT, default 16: width of one point.
REQ-003 Derived constant N = 4*2^A_BIT: transform length, 1024 at defaults.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port iCLK, input, 1: clock.
REQ-006 Port iRESET, input, 1: asynchronous active-low reset.
REQ-007 Port iFHT_RDY, input, 1: ready level from the FHT controller; high means results are valid in the banks.
REQ-008 Port iDATA_0..iDATA_3, input, D_BIT each: read data of banks 0..3, valid one cycle after the address is presented.
REQ-009 Port oADDR_RD, output, A_BIT: read address, shared by all four banks.
REQ-010 Port oRD_EN, output, 1: bank read strobe.
REQ-011 Port oDATA, output, D_BIT: output point.
REQ-012 Port oIDX, output, A_BIT+2: natural index k of the point on oDATA.
REQ-013 Port oVALID, output, 1: oDATA/oIDX/oLAST valid.
REQ-014 Port iREADY, input, 1: downstream accepts a beat.
REQ-015 Port oLAST, output, 1: marks the beat with k = N-1.
REQ-016 Port oBUSY, output, 1: an unload is in progress.
REQ-017 Port oDONE, output, 1: one-cycle pulse at unload completion.

Function
REQ-018 Point k SHALL be read from bank k[1:0] at address k[A_BIT+1:2], because the last FHT stage stores results in direct order.
REQ-019 The block SHALL have three states: IDLE, READ and DRAIN.
REQ-020 IDLE -> READ on a registered rising edge of iFHT_RDY, meaning low in cycle t-1 and high in cycle t; oRD_EN for k=0 SHALL assert in cycle t+1.
REQ-021 iFHT_RDY held high out of reset SHALL NOT start an unload; the internal edge register resets to 1.
REQ-022 A beat transfers on a clock edge where oVALID and iREADY are both high.
REQ-023 Once oVALID is high, oDATA, oIDX and oLAST SHALL be held stable until the beat transfers.
REQ-024 Output buffering SHALL be a 2-entry FIFO fed by the registered bank mux.
REQ-025 A read SHALL be issued only while (occupancy + reads in flight - pop this cycle) < 2, so the FIFO never overflows.
REQ-026 The FIFO SHALL sustain one beat per cycle while iREADY is high.
REQ-027 The bank select SHALL be pipelined alongside the read so that the mux uses the k[1:0] of the read that returned.
REQ-028 First oVALID SHALL occur 2 cycles after the first oRD_EN, i.e. cycle t+3.
REQ-029 Read index k SHALL increment by 1 per issued read; after the read of k = N-1 is issued the state SHALL move READ -> DRAIN, with no further reads and no wrap to 0.
REQ-030 DRAIN -> IDLE on the transfer of the oLAST beat; oDONE SHALL pulse in the cycle after that transfer.
REQ-031 oBUSY SHALL be high in READ and DRAIN and low in IDLE.
REQ-032 oIDX SHALL equal the k of the beat currently on oDATA.
REQ-033 Beats SHALL be emitted in strictly ascending k from 0 to N-1, with no gaps or duplicates.
REQ-034 Abort: if iFHT_RDY goes low while in READ or DRAIN (a new transform has started), the block SHALL go to IDLE next cycle, flush the FIFO and in-flight reads, drop oVALID, and not pulse oDONE.
REQ-035 A rising edge of iFHT_RDY seen in the same cycle as the oLAST transfer SHALL be ignored; a new unload requires a fresh edge observed while in IDLE.
REQ-036 iREADY low for any duration SHALL stall reads per REQ-025 without loss of data.

Reset
REQ-037 Asynchronous reset SHALL force state IDLE, k=0, FIFO empty, no reads in flight, edge register 1, and outputs oRD_EN=0, oVALID=0, oLAST=0, oBUSY=0, oDONE=0, oADDR_RD=0, oIDX=0, oDATA=0.
REQ-038 Reset asserted mid-unload SHALL discard all state; after release, no unload starts until a fresh rising edge of iFHT_RDY.

Verification
REQ-039 Bank b address a preloaded with 4a+b, iREADY=1, iFHT_RDY 0->1 -> 1024 consecutive beats with oDATA=oIDX=0..1023; oLAST only on beat 1023; oDONE one cycle after it; first oVALID at t+3.
REQ-040 Random iREADY at 30% duty -> identical 1024-beat sequence, stable data while stalled, no more than 2 beats buffered.
REQ-041 iFHT_RDY high from reset -> no oRD_EN and no oVALID for 2000 cycles.
REQ-042 iFHT_RDY dropped after 100 beats -> oVALID=0 and oBUSY=0 next cycle; no oDONE; next rising edge restarts from k=0.
REQ-043 iRESET pulsed mid-unload -> all outputs 0 immediately; restart behaves as in REQ-039.
REQ-044 iREADY=0 from t to t+10, then 1 -> oVALID at t+3 holding k=0; exactly 2 reads issued before the stall releases.

Source files
------------

// File: rtl/fht_unload.sv
// fht_unload: streams FHT results out of four direct-order banks as an indexed,
// back-pressured beat stream (oDATA/oIDX/oLAST with oVALID/iREADY handshake).
//
// Ports:
//   iCLK, iRESET        clock, asynchronous active-low reset
//   iFHT_RDY            controller ready level; a rising edge seen in IDLE starts
//                       an unload, a low level while busy aborts it
//   iDATA_0..iDATA_3    bank read data, valid one cycle after oADDR_RD/oRD_EN
//   oADDR_RD, oRD_EN    shared bank read address and read strobe
//   oDATA, oIDX, oLAST  output beat: point value, natural index k, k == N-1 marker
//   oVALID, iREADY      beat handshake; transfer when both are high
//   oBUSY, oDONE        unload in progress; one-cycle pulse after the oLAST transfer
module fht_unload #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iFHT_RDY,
  input  logic [D_BIT-1:0]   iDATA_0,
  input  logic [D_BIT-1:0]   iDATA_1,
  input  logic [D_BIT-1:0]   iDATA_2,
  input  logic [D_BIT-1:0]   iDATA_3,
  output logic [A_BIT-1:0]   oADDR_RD,
  output logic               oRD_EN,
  output logic [D_BIT-1:0]   oDATA,
  output logic [A_BIT+1:0]   oIDX,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oLAST,
  output logic               oBUSY,
  output logic               oDONE
);
  localparam int K_BIT = A_BIT + 2;
  localparam logic [K_BIT-1:0] K_MAX = '1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                 state_q, state_d;
  logic                   rdy_q;
  logic [K_BIT-1:0]       k_q, k_d;
  logic                   rd_q;
  logic [K_BIT-1:0]       rd_idx_q;
  logic [K_BIT+D_BIT-1:0] mem_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   rise, flush, push, pop, rd_en;
  logic [2:0]             load;
  logic [D_BIT-1:0]       mux;
  assign rise  = iFHT_RDY & ~rdy_q;
  // a low ready level while busy means the controller started a new transform
  assign flush = (state_q != IDLE) & ~iFHT_RDY;
  assign oVALID = cnt_q != 2'd0;
  assign pop    = oVALID & iREADY;
  // FIFO entries committed after this edge if a read were not issued now
  assign load  = 3'(cnt_q) + 3'(rd_q) - 3'(pop);
  assign rd_en = (state_q == READ) & iFHT_RDY & (load < 3'd2);
  assign push  = rd_q & ~flush;
  // bank select travels with the read so the mux matches the returning data
  assign mux = rd_idx_q[1] ? (rd_idx_q[0] ? iDATA_3 : iDATA_2)
                           : (rd_idx_q[0] ? iDATA_1 : iDATA_0);
  assign {oIDX, oDATA} = oVALID ? mem_q[rd_ptr_q] : '0;
  assign oLAST    = oVALID & (oIDX == K_MAX);
  assign oRD_EN   = rd_en;
  assign oADDR_RD = k_q[K_BIT-1:2];
  assign oBUSY    = state_q != IDLE;
  assign oDONE    = done_q;
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (rise) state_d = READ;
      READ:    if (flush) state_d = IDLE;
               else if (rd_en && k_q == K_MAX) state_d = DRAIN;
      DRAIN:   if (flush) state_d = IDLE;
               else if (pop && oLAST) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end
  // k holds at N-1 after the final read rather than wrapping
  assign k_d   = state_q == IDLE ? '0 : (rd_en && k_q != K_MAX) ? k_q + 1'b1 : k_q;
  assign cnt_d = flush ? 2'd0 : 2'(cnt_q + {1'b0, push} - {1'b0, pop});
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b1;
      k_q      <= '0;
      rd_q     <= 1'b0;
      rd_idx_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      done_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= iFHT_RDY;
      k_q      <= k_d;
      rd_q     <= rd_en;
      rd_idx_q <= k_q;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= {rd_idx_q, mux};
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end
endmodule

// File: tb/tb_fht_unload.sv
// tb_fht_unload: scoreboard bench for fht_unload with a four-bank RAM model
module tb_fht_unload;
  localparam int A = 8;
  localparam int D = 16;
  localparam int N = 4 << A;
  logic clk = 1'b0, rst_n = 1'b0, fht_rdy = 1'b1, ready = 1'b1;
  logic [D-1:0] d0, d1, d2, d3, data;
  logic [A-1:0] addr;
  logic [A+1:0] idx;
  logic rd_en, valid, last, busy, done;
  logic [D-1:0] bank [4][N/4];
  logic [A+D+2:0] exp_q [$];
  logic [A+D+2:0] held;
  int errors = 0, checks = 0, ready_mode = 0, beats = 0, reads = 0, xfers = 0;
  logic hold = 1'b0, last_xfer = 1'b0;
  always #5 clk = ~clk;
  fht_unload #(.A_BIT(A), .D_BIT(D)) dut (
    .iCLK(clk), .iRESET(rst_n), .iFHT_RDY(fht_rdy),
    .iDATA_0(d0), .iDATA_1(d1), .iDATA_2(d2), .iDATA_3(d3),
    .oADDR_RD(addr), .oRD_EN(rd_en), .oDATA(data), .oIDX(idx),
    .oVALID(valid), .iREADY(ready), .oLAST(last), .oBUSY(busy), .oDONE(done));
  always @(posedge clk) if (rd_en) begin
    d0 <= bank[0][addr];
    d1 <= bank[1][addr];
    d2 <= bank[2][addr];
    d3 <= bank[3][addr];
  end
  always @(posedge clk) begin
    #1;
    ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom_range(0, 99) < 30);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
      last_xfer = 1'b0;
      reads = 0;
      xfers = 0;
    end else begin
      if (last_xfer || done) chk("done_pulse", 32'(done), 32'(last_xfer));
      last_xfer = 1'b0;
      if (hold && valid) chk("stall_stable", 32'({last, idx, data}), 32'(held));
      if (!busy) begin
        reads = 0;
        xfers = 0;
      end
      if (rd_en) reads++;
      if (valid && ready) begin
        xfers++;
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d data %0h expected none", idx, data);
        end else chk("beat", 32'({last, idx, data}), 32'(exp_q.pop_front()));
        last_xfer = last;
      end
      if (busy) chk("outstanding_le_2", 32'((reads - xfers) <= 2), 32'd1);
      hold = valid && !ready;
      held = {last, idx, data};
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic arm(input logic [D-1:0] m);
    fht_rdy = 1'b0;
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      bank[k % 4][k / 4] = 16'(k) ^ m;
      exp_q.push_back({k == N - 1, 10'(k), 16'(k) ^ m});
    end
    fht_rdy = 1'b1;
  endtask
  task automatic run(input int limit, output int j_rd, output int j_val, output int j_done);
    j_rd = -1;
    j_val = -1;
    j_done = -1;
    for (int j = 1; j <= limit && j_done < 0; j++) begin
      tick();
      if (rd_en && j_rd < 0) j_rd = j;
      if (valid && j_val < 0) j_val = j;
      if (done) j_done = j;
    end
  endtask
  initial begin
    int jr, jv, jd, n, base;
    tick();
    tick();
    chk("reset_outputs", 32'({rd_en, valid, last, busy, done}), 32'd0);
    chk("reset_addr_idx_data", 32'({addr, idx, data}), 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int j = 0; j < 2000; j++) begin
      tick();
      if (rd_en || valid || busy) n++;
    end
    chk("rdy_high_from_reset_idle", 32'(n), 32'd0);
    arm(16'h0000);
    run(1200, jr, jv, jd);
    chk("first_rd_en_cycle", 32'(jr), 32'd1);
    chk("first_valid_cycle", 32'(jv), 32'd3);
    chk("done_cycle", 32'(jd), 32'd1027);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("idle_after_done", 32'({busy, valid}), 32'd0);
    ready_mode = 1;
    arm(16'hA5A5);
    run(9000, jr, jv, jd);
    chk("random_ready_done", 32'(jd > 0), 32'd1);
    chk("random_ready_drained", 32'(exp_q.size()), 32'd0);
    ready_mode = 2;
    arm(16'h3C3C);
    ready = 1'b0;
    n = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (rd_en) n++;
      if (j == 3) chk("stall_first_valid", 32'({valid, idx}), 32'h400);
    end
    chk("stall_reads_issued", 32'(n), 32'd2);
    chk("stall_still_k0", 32'({valid, idx}), 32'h400);
    ready_mode = 0;
    run(1200, jr, jv, jd);
    chk("stall_done", 32'(jd > 0), 32'd1);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
    arm(16'h0F0F);
    base = beats;
    for (int j = 0; j < 500 && beats - base < 100; j++) tick();
    chk("abort_reached_100", 32'(beats - base >= 100), 32'd1);
    fht_rdy = 1'b0;
    tick();
    chk("abort_idle", 32'({valid, busy, rd_en}), 32'd0);
    exp_q.delete();
    for (int j = 0; j < 5; j++) tick();
    chk("abort_stays_idle", 32'({valid, busy}), 32'd0);
    arm(16'h0000);
    run(1200, jr, jv, jd);
    chk("restart_first_valid", 32'(jv), 32'd3);
    chk("restart_done_cycle", 32'(jd), 32'd1027);
    arm(16'h1111);
    base = beats;
    for (int j = 0; j < 500 && beats - base < 50; j++) tick();
    chk("reset_reached_50", 32'(beats - base >= 50), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({rd_en, valid, last, busy, done}), 32'd0);
    chk("midreset_addr_idx_data", 32'({addr, idx, data}), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (rd_en || valid || busy) n++;
    end
    chk("no_start_after_reset", 32'(n), 32'd0);
    arm(16'h0000);
    run(1200, jr, jv, jd);
    chk("post_reset_first_rd", 32'(jr), 32'd1);
    chk("post_reset_first_valid", 32'(jv), 32'd3);
    chk("post_reset_done_cycle", 32'(jd), 32'd1027);
    chk("post_reset_drained", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule
